// File: rtl/multi_fetch_unit.sv
// Fetch stage: owns PC/OldPC/Instr, launches one fetch per IRWrite from IDLE; a fetch takes 1 cycle plus memory wait states.
// Backpressure: stall holds the controller while a fetch is outstanding; a BUSY stretch of TIMEOUT cycles latches fault until reset.
module multi_fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            IRWrite,
   input  logic            PCWrite,
   input  logic [XLEN-1:0] PCNext,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic [31:0]     mem_rdata,
   input  logic            mem_ready,
   output logic            stall,
   output logic            fault,
   output logic [XLEN-1:0] PC,
   output logic [XLEN-1:0] OldPC,
   output logic [31:0]     Instr,
   output logic [6:0]      OP,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      Rs1,
   output logic [4:0]      Rs2,
   output logic [4:0]      Rd,
   output logic [31:0]     fetch_count
);

   typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t     state;
   logic [7:0] wait_cnt;

   assign stall = (state == IDLE && IRWrite) || (state == BUSY && !mem_ready) || (state == FAULT);

   assign OP     = Instr[6:0];
   assign funct3 = Instr[14:12];
   assign funct7 = Instr[31:25];
   assign Rs1    = Instr[19:15];
   assign Rs2    = Instr[24:20];
   assign Rd     = Instr[11:7];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wait_cnt    <= 8'd0;
         PC          <= RESET_PC;
         OldPC       <= '0;
         mem_addr    <= '0;
         Instr       <= 32'h0000_0013;
         fetch_count <= 32'd0;
         mem_req     <= 1'b0;
         fault       <= 1'b0;
      end else begin
         // Gating by stall makes an IF-state PCWrite land on the completion edge.
         if (PCWrite && !stall) PC <= PCNext;
         case (state)
            IDLE: begin
               if (IRWrite) begin
                  OldPC    <= PC;
                  mem_addr <= PC;
                  wait_cnt <= 8'd0;
                  mem_req  <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready) begin
                  Instr       <= mem_rdata;
                  fetch_count <= fetch_count + 32'd1;
                  mem_req     <= 1'b0;
                  state       <= IDLE;
               end else if (wait_cnt == LAST_WAIT) begin
                  mem_req <= 1'b0;
                  fault   <= 1'b1;
                  state   <= FAULT;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/multi_fetch_unit.md
# multi_fetch_unit

Instruction-fetch stage of the multicycle RISC-V core, directly upstream of the multicycle controller. It owns the PC, OldPC and instruction registers. It launches a fetch to a variable-latency instruction memory whenever the controller requests one. It supplies the decoded fields (OP, funct3, funct7, register indices) that the controller and register file consume. While a fetch is outstanding it asserts `stall`, which the integration uses to hold the controller in IF.

## Interface
Parameters:
- XLEN, 32, data/address width
- RESET_PC, 32'h0000_0000, PC value after reset
- TIMEOUT, 15, maximum BUSY cycles without `mem_ready` before fault (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- IRWrite  in  1  controller fetch request
- PCWrite  in  1  controller PC-update request
- PCNext  in  XLEN  next PC value from the result mux
- mem_req  out  1  instruction memory request
- mem_addr  out  XLEN  fetch address
- mem_rdata  in  32  fetched instruction
- mem_ready  in  1  memory returns `mem_rdata` valid this cycle
- stall  out  1  fetch outstanding; controller must hold state
- fault  out  1  sticky fetch-timeout flag
- PC  out  XLEN  current PC
- OldPC  out  XLEN  address of the instruction held in Instr
- Instr  out  32  instruction register
- OP  out  7  Instr[6:0]
- funct3  out  3  Instr[14:12]
- funct7  out  7  Instr[31:25]
- Rs1, Rs2, Rd  out  5 each  Instr[19:15], Instr[24:20], Instr[11:7]
- fetch_count  out  32  completed-fetch counter

## Operation
- States: IDLE, BUSY, FAULT.
- IDLE:
  - `mem_req`=0.
  - If IRWrite=1: OldPC<=PC, mem_addr<=PC, wait counter<=0, go to BUSY.
  - `stall` is asserted combinationally in this cycle.
- BUSY:
  - `mem_req`=1 and `mem_addr` stable.
  - If mem_ready=1: Instr<=mem_rdata, fetch_count<=fetch_count+1 (wraps 2^32-1 -> 0), go to IDLE; `stall`=0 in this cycle.
  - Otherwise the counter increments. If the counter reaches TIMEOUT-1 with mem_ready=0, go to FAULT.
- FAULT:
  - `mem_req`=0, `stall`=1, `fault`=1.
  - Exit only by reset.
- stall = (state==IDLE && IRWrite) || (state==BUSY && !mem_ready) || (state==FAULT).
- PC update: PC<=PCNext on a clock edge where PCWrite=1 and stall=0. PCWrite while stall=1 is ignored. Because of this, the controller's IF-state PCWrite takes effect exactly on the fetch-completion edge.
- IRWrite in BUSY or FAULT does not start a new fetch. A fetch is launched only from IDLE.
- `mem_ready` outside BUSY is ignored.
- Decoded field outputs are pure slices of Instr and change only when Instr is loaded.

## Timing
- Reset values (asynchronous, while rst=0):
  - state=IDLE
  - PC=RESET_PC, OldPC=0, mem_addr=0
  - Instr=32'h0000_0013 (NOP), so OP=7'b0010011
  - fetch_count=0, fault=0, mem_req=0, stall=0
- Minimum fetch (memory ready in the first BUSY cycle):
  - cycle 0: IRWrite seen in IDLE.
  - cycle 1: mem_req=1, mem_ready=1, stall=0.
  - The edge ending cycle 1 loads Instr and PC, and the controller advances to ID.
  - The IF state therefore occupies 2 cycles.
- N wait cycles add N cycles of stall. Instr is valid the cycle after the `mem_ready` cycle.
- Timeout: FAULT is entered on the edge ending the TIMEOUT-th consecutive BUSY cycle without ready.
- Reset mid-fetch: mem_req drops immediately (asynchronously). A `mem_ready` arriving after reset release is ignored.
- A simultaneous IRWrite and mem_ready on the BUSY completion cycle completes the current fetch only. No back-to-back relaunch occurs in the same cycle.

## Test plan
- Reset: hold rst=0 with RESET_PC=32'h100.
  - Expect PC=32'h100, Instr=32'h13, OP=7'h13, mem_req=0, stall=0, fetch_count=0.
- Zero-wait fetch: IRWrite=1, PCWrite=1, PCNext=32'h104, mem_rdata=32'h00A28293 with ready in the first BUSY cycle.
  - Expect stall high for exactly 1 cycle and mem_addr=32'h100.
  - Then Instr=32'h00A28293, OP=7'h13, funct3=0, Rd=5, Rs1=5, OldPC=32'h100, PC=32'h104, fetch_count=1.
- Wait states: mem_ready delayed 3 cycles while PCWrite=1 throughout.
  - Expect stall for 4 cycles, PC unchanged until completion, mem_addr held constant.
- Timeout: TIMEOUT=4, mem_ready never asserted.
  - Expect fault=1 after 4 BUSY cycles, with mem_req=0 and stall=1.
  - The state persists through later IRWrite and mem_ready until rst=0.
- Reset mid-fetch: assert rst=0 in the second BUSY cycle.
  - Expect mem_req=0 immediately and PC=RESET_PC.
  - A late mem_ready=1 after release leaves Instr=32'h13 and fetch_count=0.
- Counter wrap: preload fetch_count to 32'hFFFF_FFFF by force, then complete one fetch.
  - Expect fetch_count=0.
